wb_uart_tx: RTL and testbench
=============================

Name: wb_uart_tx

Overview:
- Wishbone-style responder on the IO bus that accepts bytes from the CPU and serialises them onto the UART tx line as 8N1 frames.
- It is the transmit counterpart of the uart_rx path. It sits behind the interconnect's io_* port, inside the IO hub.
- Holds bytes in a small TX FIFO and a programmable baud divisor. Exposes status for polling.

Parameters:
- FIFO_DEPTH, 8, TX FIFO entries; power of 2, minimum 2.
- DIV_RESET, 16'd434, baud divisor after reset (50 MHz / 115200).

Ports:
- sys_clk  in  1  clock
- sys_rst  in  1  asynchronous, active-high reset
- io_stb_i  in  1  access request; held high until io_ack_o
- io_we_i  in  1  1 = write, 0 = read
- io_addr_i  in  32  byte address; only [3:2] decoded, base decode done upstream
- io_data_i  in  32  write data
- io_data_o  out  32  read data, valid while io_ack_o = 1
- io_ack_o  out  1  single-cycle acknowledge
- tx  out  1  serial output, idle high

Behaviour:
- Reset values (asynchronous): io_ack_o = 0, io_data_o = 0, tx = 1, FIFO empty, overflow = 0, divisor = DIV_RESET, FSM in IDLE.
- Reset mid-frame aborts the frame immediately and drops all queued bytes.
- Register map, selected by io_addr_i[3:2]:
  - 0 TXDATA: write pushes io_data_i[7:0]; read returns 0.
  - 1 STATUS, read-only:
    - bit0 busy (FSM != IDLE)
    - bit1 full
    - bit2 empty
    - bit3 overflow (sticky)
    - [15:8] FIFO count, zero-extended
    - all other bits 0
  - 2 DIVISOR: [15:0] read/write; a written value of 0 is stored as 1.
  - 3 unmapped: acknowledged; read returns 0; write is ignored.
- Handshake:
  - io_ack_o rises on the first edge at which io_stb_i = 1 and io_ack_o = 0. It is high for exactly one cycle.
  - The next access can be acknowledged no earlier than 2 cycles after the previous one.
  - Every access is acknowledged in 1 cycle; the block never stalls.
- Side effects take place on the same edge that raises io_ack_o:
  - FIFO push
  - divisor write
  - overflow clear on a STATUS read
- A TXDATA write while the FIFO is full is dropped and sets overflow. Exception: if a pop occurs on the same edge, the push is accepted.
- A STATUS read returns the overflow value from before the clear. A new overflow on the same edge wins over the clear.
- FSM, one state per frame segment: IDLE -> START -> DATA -> STOP.
  - IDLE: tx = 1. If the FIFO is not empty: pop, load the shift register, latch the divisor into bit_div, go to START.
  - START: tx = 0 for bit_div cycles.
  - DATA: 8 bits, LSB first, bit_div cycles each; 3-bit bit index.
  - STOP: tx = 1 for bit_div cycles. On the last stop cycle:
    - FIFO not empty: pop and go directly to START, with no idle gap.
    - FIFO empty: go to IDLE.
- Bit timing uses a 16-bit down-counter reloaded with bit_div - 1. A full frame is exactly 10 * bit_div cycles.
- A divisor write during a frame takes effect at the next frame start.
- Latency: for a TXDATA write into an empty, idle block, tx falls exactly 2 edges after the edge that raises io_ack_o:
  - edge 1: FSM pops
  - edge 2: START begins
- tx is a registered output and is glitch-free.

Decomposition:
- Package selen_uart_pkg holds:
  - register offsets (UART_TXDATA, UART_STATUS, UART_DIVISOR)
  - STATUS bit indices
  - typedef enum logic [1:0] uart_tx_state_t {IDLE, START, DATA, STOP}
  - DIV_W = 16
- One sub-module: uart_tx_fifo, a synchronous FIFO with parameter FIFO_DEPTH.
  - Inputs: push, pop. Outputs: full, empty, count.
  - Read data is combinational from the head entry.
  - Simultaneous push and pop when full is legal.

Test Plan:
- Reset, then read STATUS -> io_data_o = 32'h0000_0004; tx = 1; read DIVISOR returns 434.
- Write DIVISOR = 4, write TXDATA = 0xA5 -> tx low 2 edges after ack. Then 4 cycles each of: 0, then 1,0,1,0,0,1,0,1, then stop 1; total 40 cycles. busy = 1 throughout, busy = 0 afterwards.
- DIVISOR = 2, write 0x55 and 0x0F back-to-back -> two 20-cycle frames with no idle cycle between the first stop bit and the second start bit.
- DIVISOR = 1000, write 9 bytes rapidly -> the first byte pops, 8 remain; STATUS count = 8 with full = 1. A 10th write is dropped, so overflow = 1. The next STATUS read shows bit3 = 1; the following read shows bit3 = 0.
- Assert sys_rst mid-DATA of frame 0x3C -> tx = 1 asynchronously. After release: STATUS = 0x4, DIVISOR = 434, no residual frame.
- Write DIVISOR = 0 -> read returns 1. Read/write address offset 0xC -> ack in 1 cycle, read data = 0, no state change.

Source files
------------

// File: rtl/wb_uart_tx_pkg.sv
// Shared definitions for the Wishbone UART transmitter: register offsets,
// STATUS bit positions and the frame-segment state type.
package selen_uart_pkg;

   localparam int DIV_W = 16;

   localparam logic [1:0] UART_TXDATA  = 2'd0;
   localparam logic [1:0] UART_STATUS  = 2'd1;
   localparam logic [1:0] UART_DIVISOR = 2'd2;

   localparam int ST_BUSY    = 0;
   localparam int ST_FULL    = 1;
   localparam int ST_EMPTY   = 2;
   localparam int ST_OVF     = 3;
   localparam int ST_CNT_LSB = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } uart_tx_state_t;

endpackage

// File: rtl/wb_uart_tx_if.sv
// IO-bus port of the UART transmitter, grouped so master and slave share one bundle.
// Handshake: master raises io_stb_i (with we/addr/data stable) and holds it until
// io_ack_o; slave answers with a one-cycle io_ack_o, read data valid only while it is high.
interface wb_uart_tx_if;

   logic        io_stb_i;
   logic        io_we_i;
   logic [31:0] io_addr_i;
   logic [31:0] io_data_i;
   logic [31:0] io_data_o;
   logic        io_ack_o;

   modport master (
      output io_stb_i, io_we_i, io_addr_i, io_data_i,
      input  io_data_o, io_ack_o
   );

   modport slave (
      input  io_stb_i, io_we_i, io_addr_i, io_data_i,
      output io_data_o, io_ack_o
   );

endinterface

// File: rtl/wb_uart_tx_fifo.sv
// Synchronous TX byte FIFO; head entry is presented combinationally.
// A push into a full FIFO is accepted only when a pop happens on the same edge.
module uart_tx_fifo #(
   parameter  int FIFO_DEPTH = 8,
   parameter  int W          = 8,
   localparam int AW         = $clog2(FIFO_DEPTH),
   localparam int CW         = AW + 1
) (
   input  logic          i_clk,
   input  logic          i_rst,
   input  logic          i_push,
   input  logic          i_pop,
   input  logic [W-1:0]  i_wdata,
   output logic [W-1:0]  o_rdata,
   output logic          o_full,
   output logic          o_empty,
   output logic [CW-1:0] o_count
);

   logic [W-1:0]  r_mem [FIFO_DEPTH];
   logic [AW-1:0] r_wp;
   logic [AW-1:0] r_rp;
   logic [CW-1:0] r_count;
   logic          w_do_push;
   logic          w_do_pop;

   assign o_full    = (r_count == CW'(FIFO_DEPTH));
   assign o_empty   = (r_count == '0);
   assign o_count   = r_count;
   assign o_rdata   = r_mem[r_rp];
   assign w_do_pop  = i_pop & ~o_empty;
   assign w_do_push = i_push & (~o_full | w_do_pop);

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_wp    <= '0;
         r_rp    <= '0;
         r_count <= '0;
      end else begin
         if (w_do_push) r_wp <= r_wp + 1'b1;
         if (w_do_pop)  r_rp <= r_rp + 1'b1;
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge i_clk) begin
      if (w_do_push) r_mem[r_wp] <= i_wdata;
   end

endmodule

// File: rtl/wb_uart_tx.sv
// IO-bus UART transmitter: register file, TX FIFO and an 8N1 serialiser.
// tx is registered from the current state, so it trails the FSM by one cycle.
module wb_uart_tx
   import selen_uart_pkg::*;
#(
   parameter int               FIFO_DEPTH = 8,
   parameter logic [DIV_W-1:0] DIV_RESET  = 16'd434
) (
   input  logic           sys_clk,
   input  logic           sys_rst,
   wb_uart_tx_if.slave    bus,
   output logic           tx,
   output uart_tx_state_t o_dbg_state
);

   localparam int               CW  = $clog2(FIFO_DEPTH) + 1;
   localparam logic [DIV_W-1:0] ONE = 1;

   logic             r_ack;
   logic [31:0]      r_rdata;
   logic             r_ovf;
   logic [DIV_W-1:0] r_div;
   uart_tx_state_t   r_state;
   logic [DIV_W-1:0] r_cnt;
   logic [DIV_W-1:0] r_bdiv;
   logic [7:0]       r_shift;
   logic [2:0]       r_idx;
   logic             r_tx;

   uart_tx_state_t   w_state_nx;
   logic [DIV_W-1:0] w_cnt_nx;
   logic [DIV_W-1:0] w_bdiv_nx;
   logic [7:0]       w_shift_nx;
   logic [2:0]       w_idx_nx;
   logic             w_tx_nx;

   logic             w_access, w_wr, w_rd, w_push, w_pop, w_ovf_set;
   logic [1:0]       w_sel;
   logic             w_full, w_empty;
   logic [CW-1:0]    w_count;
   logic [7:0]       w_head;
   logic [31:0]      w_status, w_rdata;
   logic             w_unused;

   assign w_access  = bus.io_stb_i & ~r_ack;
   assign w_sel     = bus.io_addr_i[3:2];
   assign w_wr      = w_access & bus.io_we_i;
   assign w_rd      = w_access & ~bus.io_we_i;
   assign w_push    = w_wr & (w_sel == UART_TXDATA);
   assign w_ovf_set = w_push & w_full & ~w_pop;
   assign w_unused  = ^{bus.io_addr_i[31:4], bus.io_addr_i[1:0], bus.io_data_i[31:16]};

   assign bus.io_ack_o  = r_ack;
   assign bus.io_data_o = r_rdata;
   assign tx            = r_tx;
   assign o_dbg_state   = r_state;

   uart_tx_fifo #(.FIFO_DEPTH(FIFO_DEPTH), .W(8)) u_fifo (
      .i_clk   (sys_clk),
      .i_rst   (sys_rst),
      .i_push  (w_push),
      .i_pop   (w_pop),
      .i_wdata (bus.io_data_i[7:0]),
      .o_rdata (w_head),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_count (w_count)
   );

   always_comb begin
      w_status                             = '0;
      w_status[ST_BUSY]                    = (r_state != IDLE);
      w_status[ST_FULL]                    = w_full;
      w_status[ST_EMPTY]                   = w_empty;
      w_status[ST_OVF]                     = r_ovf;
      w_status[ST_CNT_LSB+7:ST_CNT_LSB]    = 8'(w_count);
      case (w_sel)
         UART_STATUS:  w_rdata = w_status;
         UART_DIVISOR: w_rdata = {16'h0000, r_div};
         default:      w_rdata = '0;
      endcase
   end

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         r_ack   <= 1'b0;
         r_rdata <= '0;
         r_ovf   <= 1'b0;
         r_div   <= DIV_RESET;
      end else begin
         r_ack   <= w_access;
         r_rdata <= w_rd ? w_rdata : '0;
         if (w_wr && (w_sel == UART_DIVISOR))
            r_div <= (bus.io_data_i[15:0] == '0) ? ONE : bus.io_data_i[15:0];
         // a fresh overflow on the same edge beats the read-clear
         if (w_ovf_set)
            r_ovf <= 1'b1;
         else if (w_rd && (w_sel == UART_STATUS))
            r_ovf <= 1'b0;
      end
   end

   always_comb begin
      w_state_nx = r_state;
      w_cnt_nx   = r_cnt;
      w_bdiv_nx  = r_bdiv;
      w_shift_nx = r_shift;
      w_idx_nx   = r_idx;
      w_pop      = 1'b0;
      w_tx_nx    = 1'b1;
      case (r_state)
         IDLE: begin
            if (!w_empty) begin
               w_pop      = 1'b1;
               w_state_nx = START;
            end
         end
         START: begin
            w_tx_nx = 1'b0;
            if (r_cnt == '0) begin
               w_state_nx = DATA;
               w_cnt_nx   = r_bdiv - ONE;
               w_idx_nx   = 3'd0;
            end else begin
               w_cnt_nx = r_cnt - ONE;
            end
         end
         DATA: begin
            w_tx_nx = r_shift[0];
            if (r_cnt == '0) begin
               w_cnt_nx   = r_bdiv - ONE;
               w_shift_nx = r_shift >> 1;
               if (r_idx == 3'd7) w_state_nx = STOP;
               else               w_idx_nx   = r_idx + 3'd1;
            end else begin
               w_cnt_nx = r_cnt - ONE;
            end
         end
         STOP: begin
            if (r_cnt == '0) begin
               if (!w_empty) begin
                  w_pop      = 1'b1;
                  w_state_nx = START;
               end else begin
                  w_state_nx = IDLE;
               end
            end else begin
               w_cnt_nx = r_cnt - ONE;
            end
         end
         default: w_state_nx = IDLE;
      endcase
      // divisor is sampled only at frame start
      if (w_pop) begin
         w_shift_nx = w_head;
         w_bdiv_nx  = r_div;
         w_cnt_nx   = r_div - ONE;
      end
   end

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_bdiv  <= DIV_RESET;
         r_shift <= '0;
         r_idx   <= '0;
         r_tx    <= 1'b1;
      end else begin
         r_state <= w_state_nx;
         r_cnt   <= w_cnt_nx;
         r_bdiv  <= w_bdiv_nx;
         r_shift <= w_shift_nx;
         r_idx   <= w_idx_nx;
         r_tx    <= w_tx_nx;
      end
   end

endmodule

// File: tb/tb_wb_uart_tx.sv
// Directed bench for wb_uart_tx: register access, 8N1 frame timing,
// back-to-back frames, FIFO overflow, mid-frame reset and divisor edge cases.
module tb_wb_uart_tx;
   import selen_uart_pkg::*;

   logic           sys_clk = 1'b0;
   logic           sys_rst;
   logic           tx;
   uart_tx_state_t dbg_state;
   int             n_checks = 0;
   int             n_pass   = 0;
   logic [7:0]     exp_q[$];
   logic [31:0]    rd;

   wb_uart_tx_if bus_if ();

   wb_uart_tx #(.FIFO_DEPTH(8), .DIV_RESET(16'd434)) dut (
      .sys_clk     (sys_clk),
      .sys_rst     (sys_rst),
      .bus         (bus_if),
      .tx          (tx),
      .o_dbg_state (dbg_state)
   );

   always #5 sys_clk = ~sys_clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
   endtask

   task automatic bus_access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                             output logic [31:0] rdata);
      int lat;
      lat = 0;
      @(negedge sys_clk);
      bus_if.io_stb_i  = 1'b1;
      bus_if.io_we_i   = we;
      bus_if.io_addr_i = addr;
      bus_if.io_data_i = wdata;
      do begin
         @(posedge sys_clk);
         #1;
         lat++;
      end while (!bus_if.io_ack_o && lat < 4);
      rdata            = bus_if.io_data_o;
      bus_if.io_stb_i  = 1'b0;
      bus_if.io_we_i   = 1'b0;
      check_eq("ack_latency", lat, 1);
      @(posedge sys_clk);
      #1;
      check_eq("ack_pulse", {31'b0, bus_if.io_ack_o}, 0);
   endtask

   task automatic bus_write(input logic [31:0] addr, input logic [31:0] wdata);
      logic [31:0] dummy;
      bus_access(1'b1, addr, wdata, dummy);
   endtask

   task automatic bus_read(input logic [31:0] addr, output logic [31:0] rdata);
      bus_access(1'b0, addr, 32'h0, rdata);
   endtask

   // Called at the first cycle of a start bit; walks 10 bits x div cycles.
   task automatic check_frame(input int div);
      logic [7:0] b;
      logic [9:0] bits;
      if (exp_q.size() == 0) begin
         check_eq("exp_q_underflow", 1, 0);
         return;
      end
      b    = exp_q.pop_front();
      bits = {1'b1, b, 1'b0};
      for (int k = 0; k < 10; k++) begin
         for (int c = 0; c < div; c++) begin
            check_eq($sformatf("tx_%02h_bit%0d_cyc%0d", b, k, c), {31'b0, tx}, {31'b0, bits[k]});
            @(posedge sys_clk);
            #1;
         end
      end
   endtask

   task automatic wait_tx_low(input int budget);
      int n;
      n = 0;
      while (tx !== 1'b0 && n < budget) begin
         @(posedge sys_clk);
         #1;
         n++;
      end
      check_eq("tx_start_seen", {31'b0, (tx === 1'b0)}, 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int lows;
      bus_if.io_stb_i  = 1'b0;
      bus_if.io_we_i   = 1'b0;
      bus_if.io_addr_i = 32'h0;
      bus_if.io_data_i = 32'h0;
      sys_rst          = 1'b1;
      repeat (2) @(posedge sys_clk);
      @(negedge sys_clk);
      sys_rst = 1'b0;
      @(posedge sys_clk);
      #1;

      // reset state
      check_eq("rst_ack", {31'b0, bus_if.io_ack_o}, 0);
      check_eq("rst_data_o", bus_if.io_data_o, 32'h0);
      check_eq("rst_tx", {31'b0, tx}, 1);
      check_eq("rst_state", {30'b0, dbg_state}, {30'b0, IDLE});
      bus_read(32'h4, rd);
      check_eq("rst_status", rd, 32'h0000_0004);
      bus_read(32'h8, rd);
      check_eq("rst_divisor", rd, 32'd434);

      // single frame, divisor 4, latency and bit order
      bus_write(32'h8, 32'd4);
      exp_q.push_back(8'hA5);
      bus_write(32'h0, 32'h0000_00A5);
      check_eq("tx_high_edge1", {31'b0, tx}, 1);
      check_eq("busy_after_pop", {31'b0, (dbg_state != IDLE)}, 1);
      @(posedge sys_clk);
      #1;
      check_frame(4);
      check_eq("tx_idle_after_a5", {31'b0, tx}, 1);
      bus_read(32'h4, rd);
      check_eq("status_after_a5", rd, 32'h0000_0004);

      // back-to-back frames, divisor 2, no idle gap
      bus_write(32'h8, 32'd2);
      exp_q.push_back(8'h55);
      exp_q.push_back(8'h0F);
      fork
         begin
            bus_write(32'h0, 32'h55);
            bus_write(32'h0, 32'h0F);
         end
         begin
            wait_tx_low(10);
            check_frame(2);
            check_frame(2);
            check_eq("tx_idle_after_b2b", {31'b0, tx}, 1);
         end
      join
      bus_read(32'h4, rd);
      check_eq("status_after_b2b", rd, 32'h0000_0004);

      // fill FIFO and overflow, divisor 1000
      bus_write(32'h8, 32'd1000);
      for (int i = 0; i < 9; i++) bus_write(32'h0, 32'h10 + i);
      bus_write(32'h0, 32'hEE);
      bus_read(32'h4, rd);
      check_eq("status_full_ovf", rd, 32'h0000_080B);
      bus_read(32'h4, rd);
      check_eq("status_ovf_cleared", rd, 32'h0000_0803);
      bus_read(32'h0, rd);
      check_eq("txdata_read_zero", rd, 32'h0);
      bus_read(32'h8, rd);
      check_eq("divisor_1000", rd, 32'd1000);

      // reset mid-DATA of 0x3C
      @(negedge sys_clk);
      sys_rst = 1'b1;
      @(negedge sys_clk);
      sys_rst = 1'b0;
      bus_write(32'h8, 32'd4);
      bus_write(32'h0, 32'h3C);
      repeat (6) @(posedge sys_clk);
      #1;
      check_eq("tx_low_before_rst", {31'b0, tx}, 0);
      #2;
      sys_rst = 1'b1;
      #1;
      check_eq("tx_async_rst", {31'b0, tx}, 1);
      check_eq("state_async_rst", {30'b0, dbg_state}, {30'b0, IDLE});
      repeat (2) @(posedge sys_clk);
      @(negedge sys_clk);
      sys_rst = 1'b0;
      bus_read(32'h4, rd);
      check_eq("status_after_rst", rd, 32'h0000_0004);
      bus_read(32'h8, rd);
      check_eq("divisor_after_rst", rd, 32'd434);
      lows = 0;
      for (int i = 0; i < 60; i++) begin
         @(posedge sys_clk);
         #1;
         if (tx !== 1'b1) lows++;
      end
      check_eq("no_residual_frame", lows, 0);

      // divisor zero and unmapped offset
      bus_write(32'h8, 32'd0);
      bus_read(32'h8, rd);
      check_eq("divisor_zero_to_one", rd, 32'd1);
      bus_write(32'hC, 32'hFFFF_FFFF);
      bus_read(32'hC, rd);
      check_eq("unmapped_read", rd, 32'h0);
      bus_read(32'h8, rd);
      check_eq("divisor_after_unmapped", rd, 32'd1);
      bus_read(32'h4, rd);
      check_eq("status_after_unmapped", rd, 32'h0000_0004);
      check_eq("tx_idle_final", {31'b0, tx}, 1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
